// File: rtl/rename_if.sv
// Rename-stage bus: decode request, renamed output slot, commit return and free-list occupancy.
interface rename_if #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int PTAG_W    = $clog2(PHYS_REGS)
);
  localparam int AREG_W = $clog2(ARCH_REGS);
  localparam int FC_W   = $clog2(PHYS_REGS - ARCH_REGS + 1);

  logic              decode_valid;
  logic              decode_ready;
  logic [AREG_W-1:0] decode_rs1;
  logic [AREG_W-1:0] decode_rs2;
  logic [AREG_W-1:0] decode_rd;
  logic              decode_rd_wr;
  logic              rename_valid;
  logic              dispatch_ready;
  logic [PTAG_W-1:0] rename_p_rs1;
  logic [PTAG_W-1:0] rename_p_rs2;
  logic [PTAG_W-1:0] rename_p_dest;
  logic [PTAG_W-1:0] rename_p_old;
  logic              rename_rd_wr;
  logic              commit_valid;
  logic [PTAG_W-1:0] commit_p_old;
  logic [FC_W-1:0]   free_count;

  modport master (
    output decode_valid, decode_rs1, decode_rs2, decode_rd, decode_rd_wr,
           dispatch_ready, commit_valid, commit_p_old,
    input  decode_ready, rename_valid, rename_p_rs1, rename_p_rs2,
           rename_p_dest, rename_p_old, rename_rd_wr, free_count
  );

  modport slave (
    input  decode_valid, decode_rs1, decode_rs2, decode_rd, decode_rd_wr,
           dispatch_ready, commit_valid, commit_p_old,
    output decode_ready, rename_valid, rename_p_rs1, rename_p_rs2,
           rename_p_dest, rename_p_old, rename_rd_wr, free_count
  );
endinterface

// File: rtl/rename_unit.sv
// Register rename: RAT lookup/update, circular free-list FIFO, one registered output slot.
// Optional RENAME_STALL_CNT_EN adds a saturating stall_cnt output.
module rename_unit #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int PTAG_W    = $clog2(PHYS_REGS)
) (
  input logic     clk,
  input logic     reset,
  rename_if.slave rn
`ifdef RENAME_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);
  localparam int DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int FC_W  = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTAG_W-1:0] map_q [ARCH_REGS];
  logic [PTAG_W-1:0] fl_q  [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [FC_W-1:0]   count_q;
  logic              ready, accept, alloc, push;
  logic [PTAG_W-1:0] src1, src2;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    ready  = (!rn.rename_valid || rn.dispatch_ready) && (count_q != '0);
    accept = rn.decode_valid && ready;
    alloc  = accept && rn.decode_rd_wr && (rn.decode_rd != '0);
    push   = rn.commit_valid && (rn.commit_p_old != '0) && (count_q != FC_W'(DEPTH));
    src1   = (rn.decode_rs1 == '0) ? '0 : map_q[rn.decode_rs1];
    src2   = (rn.decode_rs2 == '0) ? '0 : map_q[rn.decode_rs2];
    rn.decode_ready = ready;
    rn.free_count   = count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) map_q[i] <= PTAG_W'(i);
    end else if (alloc) begin
      map_q[rn.decode_rd] <= fl_q[head_q];
    end
  end

  // Pop reads the entry that was valid before this edge, so a tag pushed now is only poppable next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) fl_q[i] <= PTAG_W'(ARCH_REGS + i);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= FC_W'(DEPTH);
    end else begin
      if (push) begin
        fl_q[tail_q] <= rn.commit_p_old;
        tail_q       <= wrap_inc(tail_q);
      end
      if (alloc) head_q <= wrap_inc(head_q);
      case ({alloc, push})
        2'b10:   count_q <= count_q - 1'b1;
        2'b01:   count_q <= count_q + 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rn.rename_valid  <= 1'b0;
      rn.rename_p_rs1  <= '0;
      rn.rename_p_rs2  <= '0;
      rn.rename_p_dest <= '0;
      rn.rename_p_old  <= '0;
      rn.rename_rd_wr  <= 1'b0;
    end else if (accept) begin
      rn.rename_valid  <= 1'b1;
      rn.rename_p_rs1  <= src1;
      rn.rename_p_rs2  <= src2;
      rn.rename_p_dest <= alloc ? fl_q[head_q] : '0;
      rn.rename_p_old  <= alloc ? map_q[rn.decode_rd] : '0;
      rn.rename_rd_wr  <= alloc;
    end else if (rn.dispatch_ready) begin
      rn.rename_valid  <= 1'b0;
      rn.rename_p_rs1  <= '0;
      rn.rename_p_rs2  <= '0;
      rn.rename_p_dest <= '0;
      rn.rename_p_old  <= '0;
      rn.rename_rd_wr  <= 1'b0;
    end
  end

`ifdef RENAME_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (rn.decode_valid && !ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_rename_unit.sv
// Self-checking bench for rename_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_rename_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rename_if #(.ARCH_REGS(32), .PHYS_REGS(64), .PTAG_W(6)) bus();
`ifdef RENAME_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  rename_unit #(.ARCH_REGS(32), .PHYS_REGS(64), .PTAG_W(6)) dut (
    .clk(clk),
    .reset(reset),
    .rn(bus)
`ifdef RENAME_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: architectural map array, free list as a queue, retired-tag queue.
  logic [5:0] mmap [32];
  logic [5:0] fq[$];
  logic [5:0] olds[$];
  logic       e_valid, e_wr;
  logic [5:0] e_rs1, e_rs2, e_dest, e_old;
  logic [31:0] e_stall;

  function automatic logic model_ready();
    return (!e_valid || bus.dispatch_ready) && (fq.size() != 0);
  endfunction

  function automatic logic [31:0] exp_vec();
    return {e_valid, e_rs1, e_rs2, e_dest, e_old, e_wr, 6'(fq.size())};
  endfunction

  function automatic logic [31:0] got_vec();
    return {bus.rename_valid, bus.rename_p_rs1, bus.rename_p_rs2, bus.rename_p_dest,
            bus.rename_p_old, bus.rename_rd_wr, bus.free_count};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mmap[i] = 6'(i);
    fq.delete();
    for (int i = 32; i < 64; i++) fq.push_back(6'(i));
    olds.delete();
    {e_valid, e_wr, e_rs1, e_rs2, e_dest, e_old} = '0;
    e_stall = 0;
  endtask

  task automatic model_step();
    logic rdy, acc, pok;
    rdy = model_ready();
    acc = bus.decode_valid && rdy;
    pok = bus.commit_valid && (bus.commit_p_old != 0) && (fq.size() != 32);
    if (bus.decode_valid && !rdy && e_stall != 32'hFFFF_FFFF) e_stall++;
    if (acc) begin
      e_valid = 1'b1;
      e_rs1 = (bus.decode_rs1 == 0) ? 6'd0 : mmap[bus.decode_rs1];
      e_rs2 = (bus.decode_rs2 == 0) ? 6'd0 : mmap[bus.decode_rs2];
      if (bus.decode_rd_wr && bus.decode_rd != 0) begin
        e_dest = fq.pop_front();
        e_old  = mmap[bus.decode_rd];
        mmap[bus.decode_rd] = e_dest;
        e_wr = 1'b1;
        olds.push_back(e_old);
      end else begin
        e_dest = 0; e_old = 0; e_wr = 0;
      end
    end else if (bus.dispatch_ready) begin
      {e_valid, e_wr, e_rs1, e_rs2, e_dest, e_old} = '0;
    end
    if (pok) fq.push_back(bus.commit_p_old);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit dv, input int rs1, input int rs2, input int rd, input bit wr,
                       input bit dr, input bit cv, input int cp);
    bus.decode_valid   = dv;
    bus.decode_rs1     = 5'(rs1);
    bus.decode_rs2     = 5'(rs2);
    bus.decode_rd      = 5'(rd);
    bus.decode_rd_wr   = wr;
    bus.dispatch_ready = dr;
    bus.commit_valid   = cv;
    bus.commit_p_old   = 6'(cp);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (bus.rename_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0d expected 0", bus.rename_valid); end
    tests++; if ({bus.rename_p_rs1, bus.rename_p_rs2, bus.rename_p_dest, bus.rename_p_old} !== 24'd0) begin fails++; $display("FAIL reset_tags: got %h expected 0", {bus.rename_p_rs1, bus.rename_p_rs2, bus.rename_p_dest, bus.rename_p_old}); end
    tests++; if (bus.rename_rd_wr !== 1'b0) begin fails++; $display("FAIL reset_rd_wr: got %0d expected 0", bus.rename_rd_wr); end
    tests++; if (bus.free_count !== 6'd32) begin fails++; $display("FAIL reset_free_count: got %0d expected 32", bus.free_count); end
    tests++; if (bus.decode_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0d expected 1", bus.decode_ready); end
  endtask

  task automatic test_basic();
    drive(1, 1, 2, 5, 1, 1, 0, 0);
    cycle();
    tests++; if ({bus.rename_valid, bus.rename_p_rs1, bus.rename_p_rs2, bus.rename_p_dest, bus.rename_p_old, bus.rename_rd_wr} !== {1'b1, 6'd1, 6'd2, 6'd32, 6'd5, 1'b1})
      begin fails++; $display("FAIL basic_add: got %h expected %h", got_vec(), {1'b1, 6'd1, 6'd2, 6'd32, 6'd5, 1'b1, 6'd31}); end
    tests++; if (bus.free_count !== 6'd31) begin fails++; $display("FAIL basic_free_count: got %0d expected 31", bus.free_count); end
    drive(1, 5, 0, 5, 1, 1, 0, 0);
    cycle();
    tests++; if ({bus.rename_p_rs1, bus.rename_p_dest, bus.rename_p_old} !== {6'd32, 6'd33, 6'd32})
      begin fails++; $display("FAIL back_to_back: got rs1=%0d dest=%0d old=%0d expected 32 33 32", bus.rename_p_rs1, bus.rename_p_dest, bus.rename_p_old); end
    drive(1, 5, 3, 0, 1, 1, 0, 0);
    cycle();
    tests++; if ({bus.rename_p_rs1, bus.rename_p_rs2, bus.rename_p_dest, bus.rename_p_old, bus.rename_rd_wr} !== {6'd33, 6'd3, 6'd0, 6'd0, 1'b0})
      begin fails++; $display("FAIL rd_x0: got %h expected %h", got_vec(), {1'b1, 6'd33, 6'd3, 6'd0, 6'd0, 1'b0, 6'd30}); end
    tests++; if (bus.free_count !== 6'd30) begin fails++; $display("FAIL rd_x0_free_count: got %0d expected 30", bus.free_count); end
  endtask

  task automatic test_exhaust();
    do_reset();
    drive(1, 1, 2, 5, 1, 1, 0, 0);
    cycle();
    for (int i = 1; i < 32; i++) begin
      drive(1, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(1, 31), 1, 1, 0, 0);
      cycle();
    end
    tests++; if (bus.free_count !== 6'd0) begin fails++; $display("FAIL exhaust_count: got %0d expected 0", bus.free_count); end
    tests++; if (bus.decode_ready !== 1'b0) begin fails++; $display("FAIL exhaust_ready: got %0d expected 0", bus.decode_ready); end
    drive(1, 1, 1, 9, 1, 1, 0, 0);
    cycle();
    tests++; if (bus.rename_valid !== 1'b0) begin fails++; $display("FAIL exhaust_no_accept: got valid=%0d expected 0", bus.rename_valid); end
    drive(0, 0, 0, 0, 0, 1, 1, 5);
    cycle();
    tests++; if ({bus.decode_ready, bus.free_count} !== {1'b1, 6'd1}) begin fails++; $display("FAIL commit_refill: got ready=%0d count=%0d expected 1 1", bus.decode_ready, bus.free_count); end
    drive(1, 0, 0, 7, 1, 1, 0, 0);
    cycle();
    tests++; if (bus.rename_p_dest !== 6'd5) begin fails++; $display("FAIL realloc_dest: got %0d expected 5", bus.rename_p_dest); end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1, 1, 2, 3, 1, 1, 0, 0);
    cycle();
    drive(1, 3, 0, 4, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tests++; if (bus.decode_ready !== 1'b0) begin fails++; $display("FAIL stall_ready[%0d]: got %0d expected 0", i, bus.decode_ready); end
      cycle();
      tests++; if (got_vec() !== exp_vec()) begin fails++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, got_vec(), exp_vec()); end
    end
    bus.dispatch_ready = 1'b1;
    #1;
    tests++; if (bus.decode_ready !== 1'b1) begin fails++; $display("FAIL stall_release_ready: got %0d expected 1", bus.decode_ready); end
    cycle();
    tests++; if ({bus.rename_valid, bus.rename_p_rs1, bus.rename_p_dest, bus.rename_p_old} !== {1'b1, 6'd32, 6'd33, 6'd4})
      begin fails++; $display("FAIL stall_release: got %h expected %h", got_vec(), exp_vec()); end
    drive(1, 4, 3, 0, 0, 1, 0, 0);
    cycle();
    tests++; if ({bus.rename_p_rs1, bus.rename_p_rs2} !== {6'd33, 6'd32}) begin fails++; $display("FAIL stall_follow: got rs1=%0d rs2=%0d expected 33 32", bus.rename_p_rs1, bus.rename_p_rs2); end
  endtask

  task automatic test_wrap();
    logic [5:0] cp;
    do_reset();
    for (int i = 0; i < 22; i++) begin
      drive(1, 0, 0, $urandom_range(1, 31), 1, 1, 0, 0);
      cycle();
    end
    tests++; if (bus.free_count !== 6'd10) begin fails++; $display("FAIL wrap_setup: got %0d expected 10", bus.free_count); end
    for (int i = 0; i < 41; i++) begin
      cp = olds.pop_front();
      drive(1, $urandom_range(0, 31), 0, $urandom_range(1, 31), 1, 1, 1, cp);
      cycle();
      tests++; if (bus.free_count !== 6'd10) begin fails++; $display("FAIL wrap_count[%0d]: got %0d expected 10", i, bus.free_count); end
      tests++; if (got_vec() !== exp_vec()) begin fails++; $display("FAIL wrap_slot[%0d]: got %h expected %h", i, got_vec(), exp_vec()); end
    end
  endtask

  task automatic test_random();
    bit cv;
    int cp;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cv = (olds.size() != 0) && ($urandom_range(0, 1) == 1);
      cp = cv ? int'(olds.pop_front()) : 0;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, cv, cp);
      tests++; if (bus.decode_ready !== model_ready()) begin fails++; $display("FAIL rand_ready[%0d]: got %0d expected %0d", i, bus.decode_ready, model_ready()); end
      cycle();
      tests++; if (got_vec() !== exp_vec()) begin fails++; $display("FAIL rand_slot[%0d]: got %h expected %h", i, got_vec(), exp_vec()); end
`ifdef RENAME_STALL_CNT_EN
      tests++; if (stall_cnt !== e_stall) begin fails++; $display("FAIL rand_stall_cnt[%0d]: got %0d expected %0d", i, stall_cnt, e_stall); end
`endif
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_basic();
    test_exhaust();
    test_stall();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end
endmodule
